// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared RV32 fetch constants and types.
//   - mcause codes reported by the fetch stage
//   - canonical NOP encoding (addi x0, x0, 0)
//   - major opcodes recognised by the static predictor
//   - fetch_out_t: the bundle presented to decode (also the skid entry)
package rv32_fetch_pkg;

  localparam logic [3:0]  CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  CAUSE_INSTR_FAULT      = 4'd1;
  localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_BRANCH          = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL             = 7'b1101111;

  typedef struct packed {
    logic        valid;
    logic        exception;
    logic [3:0]  cause;
    logic        predicted_taken;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_out_t;

  localparam fetch_out_t FETCH_OUT_RESET = '{
    valid:           1'b0,
    exception:       1'b0,
    cause:           4'd0,
    predicted_taken: 1'b0,
    pc:              32'd0,
    instr:           NOP_INSTR
  };

endpackage

// File: rtl/rv32_fetch_if.sv
// rv32_fetch_if: instruction bus between the fetch stage and instruction memory.
//   instr_address_out   fetch -> mem  word-aligned read address
//   instr_read_out      fetch -> mem  read request, held until ready
//   instr_ready_in      mem -> fetch  response valid this cycle
//   instr_fault_in      mem -> fetch  access fault, qualified by ready
//   instr_read_value_in mem -> fetch  instruction word, qualified by ready
// Modports: master = fetch stage, slave = memory.
interface rv32_fetch_if;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in;
  logic        instr_fault_in;
  logic [31:0] instr_read_value_in;

  modport master (
    output instr_address_out, instr_read_out,
    input  instr_ready_in, instr_fault_in, instr_read_value_in
  );

  modport slave (
    input  instr_address_out, instr_read_out,
    output instr_ready_in, instr_fault_in, instr_read_value_in
  );
endinterface

// File: rtl/rv32_branch_predictor.sv
// rv32_branch_predictor: combinational static predictor.
//   pc, instr -> taken, target
// Backward conditional branches (sign bit of B-imm set) and every JAL are
// predicted taken; everything else falls through. PREDICT_ENABLE = 0 forces
// not-taken.
module rv32_branch_predictor
  import rv32_fetch_pkg::*;
#(
  parameter bit PREDICT_ENABLE = 1'b1
) (
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_branch;
  logic        is_jal;

  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign is_branch = (instr[6:0] == OPCODE_BRANCH);
  assign is_jal    = (instr[6:0] == OPCODE_JAL);

  // instr[31] is imm[12] for B-type, i.e. a negative (backward) offset.
  assign taken  = PREDICT_ENABLE && (is_jal || (is_branch && instr[31]));
  assign target = is_jal ? (pc + j_imm) : (pc + b_imm);

endmodule

// File: rtl/rv32_fetch.sv
// rv32_fetch: instruction fetch stage (producer side of fetch -> decode).
// Ports:
//   clk, reset (async, active-low)
//   stall_in, flush_in                 hazard control from the pipeline
//   trap_in/trap_pc_in                 trap/mret redirect (highest priority)
//   branch_mispredicted_in/branch_pc_in branch-resolve redirect
//   bus (rv32_fetch_if.master)         instruction memory read port
//   valid_out, exception_out, exception_cause_out,
//   branch_predicted_taken_out, pc_out, instr_out   registered to decode
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter bit          PREDICT_ENABLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                trap_in,
  input  logic [31:0]         trap_pc_in,
  input  logic                branch_mispredicted_in,
  input  logic [31:0]         branch_pc_in,
  rv32_fetch_if.master        bus,
  output logic                valid_out,
  output logic                exception_out,
  output logic [3:0]          exception_cause_out,
  output logic                branch_predicted_taken_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         instr_out
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;         // address being fetched (old address while draining)
  logic [31:0] redir_pc_reg;   // where to resume once a drain completes
  logic        misal_done_reg; // misaligned exception already presented
  fetch_out_t  skid_reg;
  fetch_out_t  out_reg;

  logic        misaligned;
  logic        read_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] fetch_next_pc;
  fetch_out_t  resp_word;
  fetch_out_t  misal_word;

  assign misaligned  = (pc_reg[1:0] != 2'b00);
  assign read_req    = ((state_reg == FETCH) && !misaligned) || (state_reg == DRAIN);
  assign redirect    = trap_in || branch_mispredicted_in;
  assign redirect_pc = trap_in ? trap_pc_in : branch_pc_in;

  assign bus.instr_read_out    = read_req;
  assign bus.instr_address_out = {pc_reg[31:2], 2'b00};

  rv32_branch_predictor #(
    .PREDICT_ENABLE (PREDICT_ENABLE)
  ) u_predictor (
    .pc     (pc_reg),
    .instr  (bus.instr_read_value_in),
    .taken  (pred_taken),
    .target (pred_target)
  );

  // A faulting response carries no usable instruction, so it is never
  // predicted and fetch simply continues sequentially.
  always_comb begin
    resp_word     = FETCH_OUT_RESET;
    fetch_next_pc = pc_reg + 32'd4;
    resp_word.valid = 1'b1;
    resp_word.pc    = pc_reg;
    if (bus.instr_fault_in) begin
      resp_word.exception = 1'b1;
      resp_word.cause     = CAUSE_INSTR_FAULT;
    end else begin
      resp_word.instr           = bus.instr_read_value_in;
      resp_word.predicted_taken = pred_taken;
      if (pred_taken) begin
        fetch_next_pc = pred_target;
      end
    end
  end

  always_comb begin
    misal_word           = FETCH_OUT_RESET;
    misal_word.valid     = 1'b1;
    misal_word.exception = 1'b1;
    misal_word.cause     = CAUSE_INSTR_MISALIGNED;
    misal_word.pc        = pc_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_VECTOR;
      redir_pc_reg   <= RESET_VECTOR;
      misal_done_reg <= 1'b0;
      skid_reg       <= FETCH_OUT_RESET;
      out_reg        <= FETCH_OUT_RESET;
    end else if (redirect) begin
      // Redirect overrides stall: the presented instruction is wrong-path.
      skid_reg          <= FETCH_OUT_RESET;
      out_reg.valid     <= 1'b0;
      out_reg.exception <= 1'b0;
      misal_done_reg    <= 1'b0;
      if (read_req && !bus.instr_ready_in) begin
        // Bus transaction still open: finish it, discard the data.
        state_reg    <= DRAIN;
        redir_pc_reg <= redirect_pc;
      end else begin
        state_reg <= FETCH;
        pc_reg    <= redirect_pc;
      end
    end else begin
      if (flush_in && !stall_in) begin
        out_reg.valid     <= 1'b0;
        out_reg.exception <= 1'b0;
      end
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH: begin
          if (misaligned) begin
            if (!misal_done_reg && !stall_in) begin
              out_reg        <= misal_word;
              misal_done_reg <= 1'b1;
            end
          end else if (bus.instr_ready_in) begin
            pc_reg <= fetch_next_pc;
            if (stall_in) begin
              skid_reg  <= resp_word;
              state_reg <= HOLD;
            end else begin
              out_reg <= resp_word;
            end
          end
        end
        DRAIN: begin
          if (bus.instr_ready_in) begin
            pc_reg    <= redir_pc_reg;
            state_reg <= FETCH;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            out_reg   <= skid_reg;
            skid_reg  <= FETCH_OUT_RESET;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign valid_out                  = out_reg.valid;
  assign exception_out              = out_reg.exception;
  assign exception_cause_out        = out_reg.cause;
  assign branch_predicted_taken_out = out_reg.predicted_taken;
  assign pc_out                     = out_reg.pc;
  assign instr_out                  = out_reg.instr;

endmodule

// File: doc/rv32_fetch.md
Name: rv32_fetch

Overview:
- Instruction fetch stage; producer end of the fetch→decode pipeline interface. Generates the PC and issues reads on the instruction bus.
- Applies static branch prediction and presents {valid, exception, cause, predicted_taken, pc, instr} registered to decode.
- Accepts redirects from the branch-resolve stage and the trap/mret path, and honours hazard stall/flush.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC of first fetch after reset.
- PREDICT_ENABLE, 1, 1 = static BTFN/JAL prediction; 0 = always predict not-taken.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- stall_in  in  1  hazard stall; decode-side outputs hold.
- flush_in  in  1  kill the instruction being presented to decode.
- trap_in  in  1  exception/interrupt/mret redirect.
- trap_pc_in  in  32  trap/mret target.
- branch_mispredicted_in  in  1  branch-resolve redirect.
- branch_pc_in  in  32  corrected PC.
- instr_address_out  out  32  bus address, word aligned.
- instr_read_out  out  1  bus read request.
- instr_ready_in  in  1  response this cycle; read_value/fault valid only when high.
- instr_fault_in  in  1  access fault, qualified by ready.
- instr_read_value_in  in  32  instruction word.
- valid_out  out  1  to decode.
- exception_out  out  1  to decode.
- exception_cause_out  out  4  to decode (mcause code).
- branch_predicted_taken_out  out  1  to decode.
- pc_out  out  32  to decode.
- instr_out  out  32  to decode.

Behaviour:
- Reset (reset low, async): pc = RESET_VECTOR, state IDLE, skid empty, pending redirect cleared.
  - Output reset values: valid_out, exception_out, branch_predicted_taken_out, instr_read_out = 0; exception_cause_out = 0; pc_out = 0; instr_out = 32'h0000_0013 (NOP).
- FSM:
  - IDLE: one cycle, no request, → FETCH.
  - FETCH: instr_read_out = 1, instr_address_out = pc. Address and read are held stable until instr_ready_in.
  - DRAIN: a redirect arrived while a request was outstanding. The request is held until ready, the response is discarded, then → FETCH at the redirect PC.
  - HOLD: skid full. No request is issued until stall_in drops.
- Response in FETCH with ready:
  - !stall_in: write the output registers, pc ← next_pc.
  - stall_in: capture the response in a 1-entry skid, → HOLD.
  - When stall_in drops in HOLD: skid → outputs, → FETCH.
- next_pc selection, priority high→low:
  - trap_in → trap_pc_in.
  - branch_mispredicted_in → branch_pc_in.
  - predicted taken → pc + imm. B-type (opcode 1100011) with imm[12]=1 uses the B-imm; JAL (1101111) always uses the J-imm.
  - otherwise pc + 4. Arithmetic is mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- A redirect in any state:
  - Clears the skid.
  - Outputs take valid_out = 0 next edge, regardless of stall_in.
  - If a request is outstanding → DRAIN, else → FETCH at the new PC.
  - Simultaneous trap_in and mispredict: trap wins.
  - Redirect on the same cycle as ready: the response is dropped, no DRAIN.
- Misaligned target (pc[1:0] ≠ 0): no bus request. Present valid_out = 1, exception_out = 1, cause 0 (instr misaligned), instr_out = NOP. Then wait in FETCH with the request suppressed until a redirect.
- Fault: ready with instr_fault_in presents exception_out = 1, cause 1 (access fault), instr_out = NOP, predicted_taken = 0. Fetch continues to pc + 4; the trap redirect follows from writeback.
- flush_in: valid_out and exception_out ← 0 on the next edge if !stall_in. pc/FSM are unaffected; the redirect arrives separately.
- stall_in without a response: all outputs hold. Bus requests continue.
- Latency: response with ready at cycle N → valid at decode at N+1. Zero-wait bus sustains 1 instr/cycle.

Decomposition:
- Constants in the shared RV32 defines header: mcause codes (INSTR_MISALIGNED = 0, INSTR_FAULT = 1), NOP encoding, opcodes BRANCH/JAL.
- FSM state enum kept local.
- One sub-module, rv32_branch_predictor: combinational, (pc, instr) → (taken, target). Gated by PREDICT_ENABLE.

Test Plan:
- Reset release, RESET_VECTOR = 32'h100, zero-wait bus → instr_address_out 100, 104, 108 on consecutive cycles; pc_out trails by 1; valid_out = 1.
- instr 32'hFE00_0EE3 (beq x0,x0,-4) at 0x108 → branch_predicted_taken_out = 1; next address 0x104.
- Mispredict with branch_pc_in = 0x200 while the bus is waiting 3 cycles → old address held, response dropped, no valid; next request at 0x200.
- stall_in high when ready arrives at 0x110 → outputs held, no new request. Stall drops → pc_out = 0x110 valid, then fetch 0x114.
- trap_pc_in = 0x202 → exception_out = 1, cause 0, no instr_read_out. Ready with fault at 0x300 → cause 1, instr_out = 32'h13.
- reset asserted mid-wait, asynchronous → instr_read_out and valid_out drop immediately. After release, refetch from RESET_VECTOR.
